// File: rtl/ec_cp0_unit.sv
// Exception-commit stage with embedded CP0 (Status/Cause/EPC/BadVAddr/Count/Compare).
// Optional Count/Compare timer interrupt enabled by defining EC_TIMER_INT_EN.
module ec_cp0_unit #(
  parameter int unsigned NUM_EXC         = 6,
  parameter int unsigned NUM_HW_INT      = 6,
  parameter int unsigned INT_SYNC_STAGES = 2,
  parameter logic [5*NUM_EXC-1:0] EXC_CODE_MAP = {5'h04, 5'h0a, 5'h0c, 5'h09, 5'h08, 5'h04}
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_HW_INT-1:0] ext_int,
  input  logic                  ec_valid,
  input  logic [NUM_EXC-1:0]    ec_ex,
  input  logic                  ec_load,
  input  logic [31:0]           ec_pc,
  input  logic [31:0]           ec_res,
  input  logic                  ec_bd,
  input  logic                  ec_eret,
  input  logic                  ec_cp0ren,
  input  logic                  ec_cp0wen,
  input  logic [7:0]            ec_cp0addr,
  input  logic [31:0]           ec_wdata,
  output logic                  exc_oc,
  output logic                  eret_oc,
  output logic                  int_pending,
  output logic [31:0]           cp0rdata,
  output logic [31:0]           cp0_epc
);

  localparam logic [7:0] ADDR_BADV    = 8'h40;
  localparam logic [7:0] ADDR_COUNT   = 8'h48;
  localparam logic [7:0] ADDR_COMPARE = 8'h58;
  localparam logic [7:0] ADDR_STATUS  = 8'h60;
  localparam logic [7:0] ADDR_CAUSE   = 8'h68;
  localparam logic [7:0] ADDR_EPC     = 8'h70;
  localparam logic [4:0] CODE_ADES    = 5'h05;
  localparam logic [4:0] CODE_INT     = 5'h00;

  logic [7:0]            im_q;
  logic                  exl_q;
  logic                  ie_q;
  logic                  bd_q;
  logic [1:0]            ip_sw_q;
  logic [4:0]            exc_code_q;
  logic [31:0]           epc_q;
  logic [31:0]           badv_q;
  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic [NUM_HW_INT-1:0] sync_q [INT_SYNC_STAGES];
  logic                  ti;

  logic [5:0]  ip_hw;
  logic [7:0]  ip;
  logic        int_req;
  logic        int_taken;
  logic        ex_any;
  logic        sel_top;
  logic        sel_bit0;
  logic [4:0]  map_code;
  logic [4:0]  exc_code_nxt;
  logic        wr_en;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;
  logic [31:0] rd_mux;

  // Interrupt view, priority select and commit strobes
  always_comb begin
    ip_hw    = 6'(sync_q[INT_SYNC_STAGES-1]);
    ip       = {ip_hw[5] | ti, ip_hw[4:0], ip_sw_q};
    int_req  = (|(ip & im_q)) & ie_q & ~exl_q;
    int_taken = ec_valid & int_req;
    ex_any   = |ec_ex;
    sel_top  = ec_ex[NUM_EXC-1];
    sel_bit0 = (ec_ex == NUM_EXC'(1));
    map_code = EXC_CODE_MAP[4:0];
    for (int i = 0; i < NUM_EXC; i++) begin
      if (ec_ex[i]) map_code = EXC_CODE_MAP[5*i +: 5];
    end
    if (int_taken)               exc_code_nxt = CODE_INT;
    else if (sel_bit0 & ~ec_load) exc_code_nxt = CODE_ADES;
    else                         exc_code_nxt = map_code;
  end

  // Reset forces the strobes low even while a commit is presented
  assign exc_oc  = resetn & (int_taken | (ec_valid & ex_any));
  assign eret_oc = resetn & ec_valid & ec_eret & ~ex_any & ~int_taken;

  // An excepting instruction never retires its MTC0
  assign wr_en      = ec_valid & ec_cp0wen & ~exc_oc;
  assign wr_status  = wr_en & (ec_cp0addr == ADDR_STATUS);
  assign wr_cause   = wr_en & (ec_cp0addr == ADDR_CAUSE);
  assign wr_epc     = wr_en & (ec_cp0addr == ADDR_EPC);
  assign wr_count   = wr_en & (ec_cp0addr == ADDR_COUNT);
  assign wr_compare = wr_en & (ec_cp0addr == ADDR_COMPARE);

  always_comb begin
    rd_mux = '0;
    case (ec_cp0addr)
      ADDR_STATUS:  rd_mux = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
      ADDR_CAUSE:   rd_mux = {bd_q, ti, 14'd0, ip, 1'b0, exc_code_q, 2'b00};
      ADDR_EPC:     rd_mux = epc_q;
      ADDR_BADV:    rd_mux = badv_q;
      ADDR_COUNT:   rd_mux = count_q;
      ADDR_COMPARE: rd_mux = compare_q;
      default:      rd_mux = '0;
    endcase
  end

  assign cp0rdata = ec_cp0ren ? rd_mux : '0;
  assign cp0_epc  = epc_q;

  // Status/Cause/EPC/BadVAddr; hardware updates are applied after MTC0 so they win
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im_q        <= '0;
      exl_q       <= 1'b0;
      ie_q        <= 1'b0;
      bd_q        <= 1'b0;
      ip_sw_q     <= '0;
      exc_code_q  <= '0;
      epc_q       <= '0;
      badv_q      <= '0;
      int_pending <= 1'b0;
      for (int s = 0; s < INT_SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int s = 1; s < INT_SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      int_pending <= int_req;
      if (wr_status) begin
        im_q  <= ec_wdata[15:8];
        exl_q <= ec_wdata[1];
        ie_q  <= ec_wdata[0];
      end
      if (wr_cause) ip_sw_q <= ec_wdata[9:8];
      if (wr_epc)   epc_q   <= ec_wdata;
      if (exc_oc) begin
        exl_q      <= 1'b1;
        exc_code_q <= exc_code_nxt;
        if (!exl_q) begin
          epc_q <= ec_bd ? ec_pc - 32'd4 : ec_pc;
          bd_q  <= ec_bd;
        end
        if (!int_taken && sel_top)       badv_q <= ec_pc;
        else if (!int_taken && sel_bit0) badv_q <= ec_res;
      end else if (eret_oc) begin
        exl_q <= 1'b0;
      end
    end
  end

`ifdef EC_TIMER_INT_EN
  logic tog_q;
  logic ti_q;

  // Count advances every second clock; TI latches on a Count/Compare match
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      compare_q <= '0;
      tog_q     <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      if (wr_count) begin
        count_q <= ec_wdata;
        tog_q   <= 1'b0;
      end else begin
        tog_q <= ~tog_q;
        if (tog_q) count_q <= count_q + 32'd1;
      end
      if (wr_compare) compare_q <= ec_wdata;
      if (count_q == compare_q) ti_q <= 1'b1;
      else if (wr_compare)      ti_q <= 1'b0;
    end
  end

  assign ti = ti_q;
`else
  // Timer disabled: Count/Compare are plain storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      if (wr_count)   count_q   <= ec_wdata;
      if (wr_compare) compare_q <= ec_wdata;
    end
  end

  assign ti = 1'b0;
`endif

endmodule

// File: tb/tb_ec_cp0_unit.sv
// Scoreboard bench for ec_cp0_unit: a per-cycle reference model pushes expected
// outputs, a monitor pops and compares on each falling edge.
module tb_ec_cp0_unit;
  localparam int NEX = 6;
  localparam int NHW = 6;
  localparam int NSYNC = 2;
  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_COMPARE = 8'h58;
  localparam logic [7:0] A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NHW-1:0] ext_int;
  logic ec_valid, ec_load, ec_bd, ec_eret, ec_cp0ren, ec_cp0wen;
  logic [NEX-1:0] ec_ex;
  logic [31:0] ec_pc, ec_res, ec_wdata;
  logic [7:0] ec_cp0addr;
  logic exc_oc, eret_oc, int_pending;
  logic [31:0] cp0rdata, cp0_epc;

  always #5 clk = ~clk;

  ec_cp0_unit dut (
    .clk(clk), .resetn(resetn), .ext_int(ext_int), .ec_valid(ec_valid), .ec_ex(ec_ex),
    .ec_load(ec_load), .ec_pc(ec_pc), .ec_res(ec_res), .ec_bd(ec_bd), .ec_eret(ec_eret),
    .ec_cp0ren(ec_cp0ren), .ec_cp0wen(ec_cp0wen), .ec_cp0addr(ec_cp0addr),
    .ec_wdata(ec_wdata), .exc_oc(exc_oc), .eret_oc(eret_oc), .int_pending(int_pending),
    .cp0rdata(cp0rdata), .cp0_epc(cp0_epc)
  );

  typedef struct {
    logic valid; logic [NEX-1:0] ex; logic load; logic [31:0] pc; logic [31:0] res;
    logic bd; logic eret; logic ren; logic wen; logic [7:0] addr; logic [31:0] wdata;
    logic [NHW-1:0] ext;
  } txn_t;
  typedef struct { logic exc; logic eret; logic ipend; logic [31:0] rdata; logic [31:0] epc; } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference state: architectural register words
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
  logic m_tog, m_ipend;
  logic [NHW-1:0] m_sync [NSYNC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, want);
    end
  endtask

  function automatic txn_t nop();
    txn_t t;
    t.valid = 0; t.ex = '0; t.load = 0; t.pc = '0; t.res = '0; t.bd = 0; t.eret = 0;
    t.ren = 0; t.wen = 0; t.addr = '0; t.wdata = '0; t.ext = '0;
    return t;
  endfunction

  function automatic logic [4:0] code_for(input int b);
    case (b)
      0: return 5'h04; 1: return 5'h08; 2: return 5'h09;
      3: return 5'h0c; 4: return 5'h0a; default: return 5'h04;
    endcase
  endfunction

  function automatic logic [31:0] m_cause_view();
    logic [31:0] v;
    v = m_cause;
    v[15:10] = v[15:10] | 6'(m_sync[NSYNC-1]);
    v[15] = v[15] | m_cause[30];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_STATUS: return m_status;
      A_CAUSE: return m_cause_view();
      A_EPC: return m_epc;
      A_BADV: return m_bad;
      A_COUNT: return m_count;
      A_COMPARE: return m_compare;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bad = 0;
    m_count = 0; m_compare = 0; m_tog = 0; m_ipend = 0;
    for (int s = 0; s < NSYNC; s++) m_sync[s] = '0;
  endtask

  // One commit cycle: outputs seen during the cycle, then state after the edge
  task automatic model_step(input txn_t t, output exp_t e);
    logic [31:0] ip;
    logic pend, int_t, exc, hit, exl_was;
    int h;
    ip = m_cause_view() & 32'h0000_FF00;
    pend = ((ip & m_status) != 0) && m_status[0] && !m_status[1];
    int_t = t.valid && pend;
    exc = int_t || (t.valid && (t.ex != 0));
    e.exc = exc;
    e.eret = t.valid && t.eret && (t.ex == 0) && !int_t;
    e.rdata = t.ren ? m_read(t.addr) : 32'h0;
    e.epc = m_epc;
    e.ipend = m_ipend;
    hit = (m_count == m_compare);
    exl_was = m_status[1];
    m_ipend = pend;
    for (int s = NSYNC - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = t.ext;
`ifdef EC_TIMER_INT_EN
    if (m_tog) m_count = m_count + 32'd1;
    m_tog = !m_tog;
`endif
    if (t.valid && t.wen && !exc) begin
      case (t.addr)
        A_STATUS: m_status = (m_status & ~32'h0000_FF03) | (t.wdata & 32'h0000_FF03);
        A_CAUSE: m_cause = (m_cause & ~32'h0000_0300) | (t.wdata & 32'h0000_0300);
        A_EPC: m_epc = t.wdata;
        A_COUNT: begin m_count = t.wdata; m_tog = 0; end
        A_COMPARE: begin m_compare = t.wdata; m_cause[30] = 1'b0; end
        default: ;
      endcase
    end
`ifdef EC_TIMER_INT_EN
    if (hit) m_cause[30] = 1'b1;
`else
    m_cause[30] = 1'b0;
`endif
    if (exc) begin
      h = -1;
      for (int i = 0; i < NEX; i++) if (t.ex[i]) h = i;
      if (int_t) m_cause[6:2] = 5'h00;
      else if (h == 0 && !t.load) m_cause[6:2] = 5'h05;
      else m_cause[6:2] = code_for(h);
      if (!exl_was) begin
        m_epc = t.bd ? t.pc - 32'd4 : t.pc;
        m_cause[31] = t.bd;
      end
      m_status[1] = 1'b1;
      if (!int_t && h == NEX - 1) m_bad = t.pc;
      else if (!int_t && h == 0) m_bad = t.res;
    end else if (e.eret) begin
      m_status[1] = 1'b0;
    end
  endtask

  task automatic apply(input txn_t t);
    ec_valid = t.valid; ec_ex = t.ex; ec_load = t.load; ec_pc = t.pc; ec_res = t.res;
    ec_bd = t.bd; ec_eret = t.eret; ec_cp0ren = t.ren; ec_cp0wen = t.wen;
    ec_cp0addr = t.addr; ec_wdata = t.wdata; ext_int = t.ext;
  endtask

  task automatic drive(input txn_t t);
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    apply(t);
    model_step(t, e);
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    txn_t t;
    t = nop(); t.valid = 1; t.wen = 1; t.addr = a; t.wdata = d;
    drive(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(nop());
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] mask,
                        input logic [31:0] want);
    txn_t t;
    t = nop(); t.ren = 1; t.addr = a;
    drive(t);
    @(negedge clk);
    chk(nm, cp0rdata & mask, want);
  endtask

  task automatic commit(input logic [NEX-1:0] ex, input logic [31:0] pc, input logic bd,
                        input logic eret, input logic [NHW-1:0] ext);
    txn_t t;
    t = nop(); t.valid = 1; t.ex = ex; t.pc = pc; t.bd = bd; t.eret = eret; t.ext = ext;
    drive(t);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    ec_valid = 1; ec_ex = NEX'(1); ec_eret = 0; ec_cp0wen = 0; ec_cp0ren = 1;
    ec_cp0addr = A_STATUS;
    #1 resetn = 1'b0;
    sbq.delete();
    #1;
    chk("rst_exc_oc", exc_oc, 0);
    chk("rst_eret_oc", eret_oc, 0);
    chk("rst_status", cp0rdata, 32'h0040_0000);
    chk("rst_epc", cp0_epc, 0);
    chk("rst_int_pending", int_pending, 0);
    repeat (2) @(posedge clk);
    #2;
    apply(nop());
    model_reset();
    resetn = 1'b1;
  endtask

  // Monitor: one expected entry per driven cycle
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("exc_oc", exc_oc, e.exc);
      chk("eret_oc", eret_oc, e.eret);
      chk("cp0rdata", cp0rdata, e.rdata);
      chk("cp0_epc", cp0_epc, e.epc);
      chk("int_pending", int_pending, e.ipend);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    logic [NHW-1:0] ext_st;
    logic [7:0] alist [6];
    alist[0] = A_STATUS; alist[1] = A_CAUSE; alist[2] = A_EPC;
    alist[3] = A_BADV; alist[4] = A_COUNT; alist[5] = A_COMPARE;
    apply(nop());
    model_reset();
    #22 resetn = 1'b1;

    rd_chk("reset_status", A_STATUS, 32'hFFFF_FFFF, 32'h0040_0000);
    rd_chk("reset_cause", A_CAUSE, 32'hBFFF_FFFF, 32'h0);
    chk("reset_epc", cp0_epc, 32'h0);

    // Priority: RI beats syscall and AdEL; nested exception keeps EPC and drops its MTC0
    commit(6'b010011, 32'h0000_1000, 0, 0, '0);
    chk("prio_exc_oc", exc_oc, 1);
    rd_chk("prio_code", A_CAUSE, 32'h8000_007C, 32'h0000_0028);
    rd_chk("prio_exl", A_STATUS, 32'h2, 32'h2);
    chk("prio_epc", cp0_epc, 32'h0000_1000);
    t = nop(); t.valid = 1; t.ex = 6'b000010; t.pc = 32'h2000;
    t.wen = 1; t.addr = A_EPC; t.wdata = 32'hDEAD_BEEF;
    drive(t);
    @(negedge clk);
    chk("nested_exc_oc", exc_oc, 1);
    rd_chk("nested_code", A_CAUSE, 32'h0000_007C, 32'h0000_0020);
    chk("nested_epc_kept", cp0_epc, 32'h0000_1000);

    commit('0, 32'h3000, 0, 1, '0);
    chk("eret_oc", eret_oc, 1);
    chk("eret_no_exc", exc_oc, 0);
    rd_chk("eret_exl_clr", A_STATUS, 32'h2, 32'h0);

    commit(6'b010000, 32'h3000, 0, 1, '0);
    chk("eret_ex_exc", exc_oc, 1);
    chk("eret_ex_no_eret", eret_oc, 0);
    commit('0, 32'h0, 0, 1, '0);

    // Store address fault in a delay slot
    t = nop(); t.valid = 1; t.ex = 6'b000001; t.pc = 32'h8000_0104; t.bd = 1; t.res = 32'h1003;
    drive(t);
    rd_chk("ds_cause", A_CAUSE, 32'h8000_007C, 32'h8000_0014);
    chk("ds_epc", cp0_epc, 32'h8000_0100);
    rd_chk("ds_badv", A_BADV, 32'hFFFF_FFFF, 32'h0000_1003);
    commit('0, 32'h0, 0, 1, '0);

    commit(6'b100000, 32'h0000_0ABC, 0, 0, '0);
    rd_chk("fetch_badv", A_BADV, 32'hFFFF_FFFF, 32'h0000_0ABC);
    rd_chk("fetch_code", A_CAUSE, 32'h0000_007C, 32'h0000_0010);
    commit('0, 32'h0, 0, 1, '0);

    commit(6'b000100, 32'h0, 1, 0, '0);
    rd_chk("wrap_code", A_CAUSE, 32'h8000_007C, 32'h8000_0024);
    chk("wrap_epc", cp0_epc, 32'hFFFF_FFFC);
    commit('0, 32'h0, 0, 1, '0);

    // Hardware interrupt on line 0 with IM2/IE, two-stage synchroniser
    wr(A_STATUS, 32'h0000_0401);
    commit('0, 32'h4000, 0, 0, NHW'(1));
    chk("int_too_early", exc_oc, 0);
    t = nop(); t.ext = NHW'(1);
    drive(t);
    commit('0, 32'h4008, 0, 0, NHW'(1));
    chk("int_taken", exc_oc, 1);
    rd_chk("int_code", A_CAUSE, 32'h0000_007C, 32'h0);
    chk("int_epc", cp0_epc, 32'h4008);
    commit('0, 32'h400C, 0, 0, NHW'(1));
    chk("int_masked_exl", exc_oc, 0);
    idle(3);
    commit('0, 32'h0, 0, 1, '0);
    chk("int_eret_oc", eret_oc, 1);
    wr(A_STATUS, 32'h0);

    wr(A_COMPARE, 32'd5);
    wr(A_COUNT, 32'd0);
    wr(A_STATUS, 32'h0000_8001);
    idle(6);
`ifdef EC_TIMER_INT_EN
    rd_chk("ti_early", A_CAUSE, 32'h4000_0000, 32'h0);
    idle(4);
    rd_chk("ti_set", A_CAUSE, 32'h4000_0000, 32'h4000_0000);
    wr(A_COMPARE, 32'h1000);
    rd_chk("ti_cleared", A_CAUSE, 32'h4000_0000, 32'h0);
`else
    idle(5);
    rd_chk("ti_off", A_CAUSE, 32'h4000_8000, 32'h0);
    rd_chk("count_static", A_COUNT, 32'hFFFF_FFFF, 32'h0);
`endif
    wr(A_STATUS, 32'h0);

    // Randomised commits, MTC0/MFC0 traffic and interrupt lines
    ext_st = '0;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      if ($urandom_range(0, 19) == 0) ext_st = $urandom_range(0, 1) ? NHW'($urandom) : '0;
      t = nop();
      t.valid = ($urandom_range(0, 9) < 7);
      t.ex = ($urandom_range(0, 4) == 0) ? NEX'($urandom) : '0;
      t.load = 1'($urandom);
      t.pc = $urandom;
      t.res = $urandom;
      t.bd = 1'($urandom);
      t.eret = ($urandom_range(0, 9) == 0);
      t.wen = ($urandom_range(0, 6) == 0);
      t.ren = 1'($urandom);
      t.addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : alist[$urandom_range(0, 5)];
      t.wdata = $urandom;
      if ($urandom_range(0, 1) == 0) t.wdata[1] = 1'b0;
      t.ext = ext_st;
      drive(t);
    end

    idle(2);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
